key_event_fifo: RTL and testbench

Receive-side endpoint for the button scanner's byte output. Samples the scanner's ready strobe and 8-bit one-hot button code, validates and encodes the code to a 3-bit ticket index, and buffers events in a small FIFO. The ticket-selection FSM drains the FIFO with a read-enable handshake. Also reports malformed codes and overflow drops.

---
 rtl/key_event_fifo.sv | 119 +++++++++++
 tb/tb_key_event_fifo.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/key_event_fifo.sv
// key_event_fifo: edge-detects scanner strobes, encodes one-hot codes and queues ticket indices in a FWFT FIFO
// Optional KEY_DEDUP_EN suppresses repeats of the last accepted index within HOLDOFF cycles.
module key_event_fifo #(
    parameter int DEPTH   = 4,
    parameter int HOLDOFF = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_RDY,
    input  logic [7:0]                 DATA_in,
    input  logic                       rd_en,
    output logic                       out_VALID,
    output logic [2:0]                 ticket_idx,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       bad_code,
    output logic                       drop
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || HOLDOFF < 1) begin : g_bad_cfg
        $error("key_event_fifo: DEPTH must be a power of two >= 2 and HOLDOFF >= 1");
    end

    logic          in_rdy_d;
    logic          ev_ok;
    logic          ev_bad;
    logic [2:0]    ev_idx;
    logic          onehot;
    logic [2:0]    enc;
    logic          strobe;
    logic          dup;
    logic          pop;
    logic          push;
    logic          lost;
    logic [CW-1:0] count_nxt;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [2:0]    mem [DEPTH];

    always_comb begin
        enc = '0;
        for (int i = 0; i < 8; i++)
            if (DATA_in[i]) enc = 3'(i);
        onehot = (DATA_in != 8'd0) && ((DATA_in & (DATA_in - 8'd1)) == 8'd0);
        strobe = in_RDY & ~in_rdy_d;
    end

    // Stage 1: capture the event on the strobe's rising edge; it is acted on one edge later.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_rdy_d <= 1'b0;
            ev_ok    <= 1'b0;
            ev_bad   <= 1'b0;
            ev_idx   <= '0;
        end else begin
            in_rdy_d <= in_RDY;
            ev_ok    <= strobe & onehot;
            ev_bad   <= strobe & ~onehot;
            ev_idx   <= enc;
        end
    end

`ifdef KEY_DEDUP_EN
    localparam int HW = $clog2(HOLDOFF + 1);
    logic [2:0]    last_idx;
    logic [HW-1:0] hold_cnt;

    // hold_cnt > 1 at the decision edge means fewer than HOLDOFF edges since the last accept.
    assign dup = ev_ok && (ev_idx == last_idx) && (hold_cnt > HW'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            last_idx <= '0;
            hold_cnt <= '0;
        end else if (push) begin
            last_idx <= ev_idx;
            hold_cnt <= HW'(HOLDOFF);
        end else if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - HW'(1);
        end
    end
`else
    assign dup = 1'b0;
`endif

    always_comb begin
        pop       = rd_en & out_VALID;
        push      = ev_ok & ~dup & (~full | pop);
        lost      = ev_ok & ~dup & full & ~pop;
        count_nxt = count + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_VALID <= 1'b0;
            full      <= 1'b0;
            bad_code  <= 1'b0;
            drop      <= 1'b0;
        end else begin
            count     <= count_nxt;
            out_VALID <= count_nxt != '0;
            full      <= count_nxt == CW'(DEPTH);
            bad_code  <= ev_bad;
            drop      <= lost;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
        end
    end

    always_ff @(posedge clk)
        if (!rst && push) mem[wr_ptr] <= ev_idx;

    assign ticket_idx = out_VALID ? mem[rd_ptr] : 3'd0;
endmodule

// File: tb/tb_key_event_fifo.sv
// tb_key_event_fifo: directed and randomized checks of key_event_fifo against a queue-based reference model
module tb_key_event_fifo;
    localparam int DEPTH   = 4;
    localparam int HOLDOFF = 8;
`ifdef KEY_DEDUP_EN
    localparam bit DEDUP = 1'b1;
`else
    localparam bit DEDUP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_RDY = 1'b0;
    logic [7:0] DATA_in = '0;
    logic       rd_en = 1'b0;
    logic       out_VALID;
    logic [2:0] ticket_idx;
    logic       full;
    logic [2:0] count;
    logic       bad_code;
    logic       drop;

    key_event_fifo #(.DEPTH(DEPTH), .HOLDOFF(HOLDOFF)) dut (
        .clk(clk), .rst(rst), .in_RDY(in_RDY), .DATA_in(DATA_in), .rd_en(rd_en),
        .out_VALID(out_VALID), .ticket_idx(ticket_idx), .full(full), .count(count),
        .bad_code(bad_code), .drop(drop)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: the FIFO is a queue; an event is acted on one edge after its strobe edge.
    int q[$];
    bit m_prev = 0;
    bit m_pend_ok = 0;
    bit m_pend_bad = 0;
    int m_pend_idx = 0;
    bit m_bad = 0;
    bit m_drop = 0;
    int m_last_idx = -1;
    int m_last_cyc = -1000;
    int m_cyc = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int bit_pos(input logic [7:0] d);
        for (int i = 0; i < 8; i++)
            if (d[i]) return i;
        return 0;
    endfunction

    task automatic model_edge(input bit r, input bit rdy, input logic [7:0] d, input bit rd);
        bit dup;
        if (r) begin
            q.delete();
            m_prev = 0; m_pend_ok = 0; m_pend_bad = 0;
            m_bad = 0; m_drop = 0; m_last_idx = -1; m_last_cyc = -1000;
        end else begin
            dup = DEDUP && m_pend_ok && m_pend_idx == m_last_idx && (m_cyc - m_last_cyc) < HOLDOFF;
            m_bad = m_pend_bad;
            m_drop = 0;
            if (rd && q.size() > 0) void'(q.pop_front());
            if (m_pend_ok && !dup) begin
                if (q.size() < DEPTH) begin
                    q.push_back(m_pend_idx);
                    m_last_idx = m_pend_idx;
                    m_last_cyc = m_cyc;
                end else m_drop = 1;
            end
            m_pend_ok  = rdy && !m_prev && $countones(d) == 1;
            m_pend_bad = rdy && !m_prev && $countones(d) != 1;
            m_pend_idx = bit_pos(d);
            m_prev = rdy;
        end
        m_cyc++;
    endtask

    // Drive inputs, advance one clock, then compare every output on the falling edge.
    task automatic step(input bit rdy, input logic [7:0] d, input bit rd, input bit r);
        in_RDY = rdy; DATA_in = d; rd_en = rd; rst = r;
        model_edge(r, rdy, d, rd);
        @(posedge clk);
        @(negedge clk);
        check("count", int'(count), q.size());
        check("out_VALID", int'(out_VALID), int'(q.size() != 0));
        check("full", int'(full), int'(q.size() == DEPTH));
        check("bad_code", int'(bad_code), int'(m_bad));
        check("drop", int'(drop), int'(m_drop));
        if (q.size() != 0) check("ticket_idx", int'(ticket_idx), q[0]);
        if (r) check("ticket_idx_rst", int'(ticket_idx), 0);
    endtask

    task automatic pulse(input logic [7:0] d);
        step(1, d, 0, 0);
        step(0, 8'h00, 0, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 8'h00, 0, 0);
    endtask

    initial begin
        logic [7:0] codes [4] = '{8'h10, 8'h04, 8'h80, 8'h01};
        @(negedge clk);
        step(0, 8'h00, 0, 1);
        step(0, 8'h00, 0, 1);
        check("reset_count", int'(count), 0);

        pulse(8'h10);
        check("first_idx", int'(ticket_idx), 4);
        step(0, 8'h00, 1, 0);
        check("first_pop_valid", int'(out_VALID), 0);

        foreach (codes[i]) pulse(codes[i]);
        check("full_after_four", int'(full), 1);
        step(1, 8'h02, 0, 0);
        step(0, 8'h00, 0, 0);
        check("drop_on_full", int'(drop), 1);
        for (int i = 0; i < 5; i++) step(0, 8'h00, 1, 0);
        check("drained", int'(count), 0);

        pulse(8'h00);
        check("bad_zero", int'(bad_code), 1);
        pulse(8'h11);
        check("bad_two_bits", int'(bad_code), 1);

        for (int i = 0; i < 5; i++) step(1, 8'h04, 0, 0);
        step(0, 8'h00, 0, 0);
        check("held_high_one_entry", int'(count), 1);
        step(0, 8'h00, 1, 0);

        foreach (codes[i]) pulse(codes[i]);
        step(1, 8'h08, 0, 0);
        step(0, 8'h00, 1, 0);
        check("full_push_pop_no_drop", int'(drop), 0);
        check("full_push_pop_count", int'(count), 4);
        for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0);

        pulse(8'h02);
        pulse(8'h40);
        step(1, 8'h20, 0, 1);
        step(0, 8'h00, 0, 0);
        check("reset_flush", int'(count), 0);
        idle(HOLDOFF + 2);

        step(1, 8'h04, 0, 0); idle(3);
        step(1, 8'h04, 0, 0); idle(1);
        check("dedup_close", int'(count), DEDUP ? 1 : 2);
        idle(8);
        step(1, 8'h04, 0, 0); idle(1);
        step(1, 8'h08, 0, 0); idle(1);
        for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0);

        for (int i = 0; i < 3000; i++) begin
            logic [7:0] d;
            d = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'(1 << $urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) d = 8'h04;
            step($urandom_range(0, 1) == 1, d, $urandom_range(0, 2) == 0, $urandom_range(0, 199) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
